ring_buf_ctrl: RTL and testbench

RING_BUF_CTRL -- requirements
Module: ring_buf_ctrl

---
 rtl/ring_buf_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ring_buf_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ring_buf_ctrl
//  Description : Controller for a ring buffer held in an external register
//                array. Accepts a valid/ready upstream stream, waits until a
//                configured number of entries has accumulated, then streams
//                words out through a registered valid/ready output stage.
//                A flush stops intake and drains whatever is left.
//
//  Ports
//    clk, rst      : single clock, synchronous active-high reset
//    s_valid/s_ready/s_data : upstream stream (push = s_valid & s_ready)
//    m_valid/m_ready/m_data : registered downstream stream
//    cfg_depth     : entries required before reading starts
//    flush         : end of stream, stop accepting and drain
//    arr_wr_en/arr_wr_ptr/arr_wr_data : register array write port
//    arr_rd_ptr/arr_rd_data           : register array read port (comb read)
//    count, full, empty               : occupancy status
//
//  Revision    : 1.0  initial release
// ============================================================================
module ring_buf_ctrl #(
  parameter int BIT_WIDTH = 8,
  parameter int BUF_WIDTH = 9,
  parameter int BUF_SIZE  = 257
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [BIT_WIDTH-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [BIT_WIDTH-1:0] m_data,
  input  logic [BUF_WIDTH-1:0] cfg_depth,
  input  logic                 flush,
  output logic                 arr_wr_en,
  output logic [BUF_WIDTH-1:0] arr_wr_ptr,
  output logic [BIT_WIDTH-1:0] arr_wr_data,
  output logic [BUF_WIDTH-1:0] arr_rd_ptr,
  input  logic [BIT_WIDTH-1:0] arr_rd_data,
  output logic [BUF_WIDTH-1:0] count,
  output logic                 full,
  output logic                 empty
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_FILL   = 2'd1;
  localparam logic [1:0] C_STREAM = 2'd2;
  localparam logic [1:0] C_DRAIN  = 2'd3;

  // count must be able to represent BUF_SIZE itself, so BUF_SIZE fits BUF_WIDTH
  localparam logic [BUF_WIDTH-1:0] C_SIZE = BUF_WIDTH'(BUF_SIZE);
  localparam logic [BUF_WIDTH-1:0] C_LAST = BUF_WIDTH'(BUF_SIZE - 1);
  localparam logic [BUF_WIDTH-1:0] C_ONE  = BUF_WIDTH'(1);

  logic [1:0]           state_q,   state_d;
  logic [BUF_WIDTH-1:0] wr_ptr_q,  wr_ptr_d;
  logic [BUF_WIDTH-1:0] rd_ptr_q,  rd_ptr_d;
  logic [BUF_WIDTH-1:0] count_q,   count_d;
  logic [BUF_WIDTH-1:0] depth_q,   depth_d;
  logic                 m_valid_q, m_valid_d;
  logic [BIT_WIDTH-1:0] m_data_q,  m_data_d;

  logic push;
  logic pop;
  logic full_w;
  logic empty_w;

  // Pointers wrap at BUF_SIZE-1, which is generally not a power of two.
  function automatic logic [BUF_WIDTH-1:0] next_ptr(input logic [BUF_WIDTH-1:0] p);
    next_ptr = (p == C_LAST) ? '0 : p + C_ONE;
  endfunction

  assign full_w  = (count_q == C_SIZE);
  assign empty_w = (count_q == '0);

  // Ready depends only on registered state, so a pop in the same cycle
  // cannot open a slot for a push while full.
  assign s_ready = !full_w && (state_q != C_DRAIN);
  assign push    = s_valid && s_ready;

  // The output register may be reloaded when it is empty or being taken.
  assign pop = ((state_q == C_STREAM) || (state_q == C_DRAIN)) && !empty_w &&
               (!m_valid_q || m_ready);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    depth_d   = depth_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;

    if (push) begin
      wr_ptr_d = next_ptr(wr_ptr_q);
    end

    if (pop) begin
      rd_ptr_d  = next_ptr(rd_ptr_q);
      m_valid_d = 1'b1;
      m_data_d  = arr_rd_data;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end

    if (push && !pop) begin
      count_d = count_q + C_ONE;
    end else if (pop && !push) begin
      count_d = count_q - C_ONE;
    end

    case (state_q)
      C_IDLE: begin
        if (push) begin
          state_d = C_FILL;
          if (cfg_depth == '0) begin
            depth_d = C_ONE;
          end else if (cfg_depth > C_SIZE) begin
            depth_d = C_SIZE;
          end else begin
            depth_d = cfg_depth;
          end
        end
      end
      C_FILL: begin
        if (flush) begin
          state_d = C_DRAIN;
        end else if (count_q >= depth_q) begin
          state_d = C_STREAM;
        end
      end
      C_STREAM: begin
        // Running dry keeps streaming; only a flush ends the stream.
        if (flush) begin
          state_d = C_DRAIN;
        end
      end
      C_DRAIN: begin
        // A word still sitting in the output register stays valid in IDLE.
        if (empty_w) begin
          state_d = C_IDLE;
        end
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= C_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      depth_q   <= C_ONE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      depth_q   <= depth_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign arr_wr_en   = push;
  assign arr_wr_ptr  = wr_ptr_q;
  assign arr_wr_data = s_data;
  assign arr_rd_ptr  = rd_ptr_q;
  assign count       = count_q;
  assign full        = full_w;
  assign empty       = empty_w;

endmodule
`default_nettype wire

// File: tb/tb_ring_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ring_buf_ctrl
//  Description : Self-checking bench for ring_buf_ctrl. Models the external
//                register array, applies a directed vector table and a few
//                multi-cycle sequences (full buffer, pointer wrap, flush,
//                reset mid-stream, startup latency).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ring_buf_ctrl;

  localparam int BW = 8;
  localparam int PW = 9;
  localparam int BS = 257;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [BW-1:0] m_data;
  logic [PW-1:0] cfg_depth;
  logic          flush;
  logic          arr_wr_en;
  logic [PW-1:0] arr_wr_ptr;
  logic [BW-1:0] arr_wr_data;
  logic [PW-1:0] arr_rd_ptr;
  logic [BW-1:0] arr_rd_data;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;

  always #5 clk = ~clk;

  ring_buf_ctrl #(.BIT_WIDTH(BW), .BUF_WIDTH(PW), .BUF_SIZE(BS)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .cfg_depth(cfg_depth), .flush(flush),
    .arr_wr_en(arr_wr_en), .arr_wr_ptr(arr_wr_ptr), .arr_wr_data(arr_wr_data),
    .arr_rd_ptr(arr_rd_ptr), .arr_rd_data(arr_rd_data),
    .count(count), .full(full), .empty(empty)
  );

  // Register array model: synchronous write, combinational read.
  logic [BW-1:0] mem [0:BS-1];
  always @(posedge clk) begin
    if (arr_wr_en && (arr_wr_ptr < PW'(BS))) mem[arr_wr_ptr] <= arr_wr_data;
  end
  assign arr_rd_data = (arr_rd_ptr < PW'(BS)) ? mem[arr_rd_ptr] : '0;

  typedef struct {
    logic          rst, sv;
    logic [BW-1:0] sd;
    logic          mr;
    logic [PW-1:0] cfg;
    logic          fl;
    logic          e_mv;
    logic [BW-1:0] e_md;
    logic [PW-1:0] e_cnt;
    logic          e_srdy;
    logic [PW-1:0] e_wr, e_rd;
  } vec_t;

  vec_t          tbl [24];
  int            vecs = 0;
  int            errs = 0;
  logic [BW-1:0] exp_q [$];
  logic          prev_hold = 1'b0;
  logic [BW-1:0] prev_data = '0;

  function automatic vec_t mk(input logic r, sv, input logic [7:0] sd, input logic mr,
                              input logic [8:0] cfg, input logic fl, input logic mv,
                              input logic [7:0] md, input logic [8:0] cnt,
                              input logic srdy, input logic [8:0] wr, rd);
    vec_t v;
    v.rst = r; v.sv = sv; v.sd = sd; v.mr = mr; v.cfg = cfg; v.fl = fl;
    v.e_mv = mv; v.e_md = md; v.e_cnt = cnt; v.e_srdy = srdy; v.e_wr = wr; v.e_rd = rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard for words leaving the output port, plus hold stability.
  task automatic observe();
    logic [BW-1:0] e;
    if (prev_hold) chk("hold_stable", {m_valid, m_data}, {1'b1, prev_data});
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", {1'b1, m_data}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk("m_data_order", m_data, e);
      end
    end
    prev_hold = m_valid && !m_ready;
    prev_data = m_data;
  endtask

  task automatic step();
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", exp_q.size(), 0);
    m_ready = 1'b1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;
    cfg_depth = 9'd4; flush = 1'b0;

    //          rst sv sd     mr cfg fl   mv md     cnt srdy wr rd
    tbl[0]  = mk(1, 0, 8'h00, 1, 4, 0,   0, 8'h00, 0, 1, 0, 0);
    tbl[1]  = mk(0, 1, 8'h10, 1, 4, 0,   0, 8'h00, 1, 1, 1, 0);
    tbl[2]  = mk(0, 1, 8'h11, 1, 4, 0,   0, 8'h00, 2, 1, 2, 0);
    tbl[3]  = mk(0, 1, 8'h12, 1, 4, 0,   0, 8'h00, 3, 1, 3, 0);
    tbl[4]  = mk(0, 1, 8'h13, 1, 4, 0,   0, 8'h00, 4, 1, 4, 0);
    tbl[5]  = mk(0, 0, 8'h00, 1, 4, 0,   0, 8'h00, 4, 1, 4, 0);
    tbl[6]  = mk(0, 0, 8'h00, 1, 4, 0,   1, 8'h10, 3, 1, 4, 1);
    tbl[7]  = mk(0, 0, 8'h00, 1, 4, 0,   1, 8'h11, 2, 1, 4, 2);
    tbl[8]  = mk(0, 0, 8'h00, 1, 4, 0,   1, 8'h12, 1, 1, 4, 3);
    tbl[9]  = mk(0, 0, 8'h00, 1, 4, 0,   1, 8'h13, 0, 1, 4, 4);
    tbl[10] = mk(0, 0, 8'h00, 1, 4, 0,   0, 8'h13, 0, 1, 4, 4);
    tbl[11] = mk(0, 1, 8'h20, 1, 4, 0,   0, 8'h13, 1, 1, 5, 4);
    tbl[12] = mk(0, 0, 8'h00, 1, 4, 0,   1, 8'h20, 0, 1, 5, 5);
    tbl[13] = mk(0, 1, 8'h21, 0, 4, 0,   1, 8'h20, 1, 1, 6, 5);
    tbl[14] = mk(0, 0, 8'h00, 0, 4, 0,   1, 8'h20, 1, 1, 6, 5);
    tbl[15] = mk(0, 0, 8'h00, 0, 4, 1,   1, 8'h20, 1, 0, 6, 5);
    tbl[16] = mk(0, 1, 8'h99, 1, 4, 0,   1, 8'h21, 0, 0, 6, 6);
    tbl[17] = mk(0, 0, 8'h00, 1, 4, 0,   0, 8'h21, 0, 1, 6, 6);
    tbl[18] = mk(0, 0, 8'h00, 1, 4, 1,   0, 8'h21, 0, 1, 6, 6);
    tbl[19] = mk(0, 1, 8'h30, 1, 0, 0,   0, 8'h21, 1, 1, 7, 6);
    tbl[20] = mk(0, 0, 8'h00, 1, 0, 0,   0, 8'h21, 1, 1, 7, 6);
    tbl[21] = mk(0, 0, 8'h00, 1, 0, 0,   1, 8'h30, 0, 1, 7, 7);
    tbl[22] = mk(0, 0, 8'h00, 1, 0, 0,   0, 8'h30, 0, 1, 7, 7);
    tbl[23] = mk(1, 1, 8'h55, 1, 0, 0,   0, 8'h00, 0, 1, 0, 0);

    #1;
    for (int i = 0; i < 24; i++) begin
      rst = tbl[i].rst; s_valid = tbl[i].sv; s_data = tbl[i].sd;
      m_ready = tbl[i].mr; cfg_depth = tbl[i].cfg; flush = tbl[i].fl;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d {mv,md,cnt,srdy,full,empty,wr,rd}", i),
          {m_valid, m_data, count, s_ready, full, empty, arr_wr_ptr, arr_rd_ptr},
          {tbl[i].e_mv, tbl[i].e_md, tbl[i].e_cnt, tbl[i].e_srdy,
           tbl[i].e_cnt == 9'(BS), tbl[i].e_cnt == 9'd0, tbl[i].e_wr, tbl[i].e_rd});
    end

    // Fill to capacity with the output stalled, then drain with random ready.
    rst = 1'b0; s_valid = 1'b0; flush = 1'b0; m_ready = 1'b0; cfg_depth = 9'd257;
    for (int i = 0; i < BS; i++) begin
      s_valid = 1'b1; s_data = 8'(i) ^ 8'h5A;
      exp_q.push_back(s_data);
      step();
    end
    s_data = 8'hEE;
    chk("full_flag", full, 1);
    chk("full_s_ready", s_ready, 0);
    chk("full_wr_ptr_wrapped", arr_wr_ptr, 0);
    chk("full_count", count, 257);
    step();
    chk("full_count_fill_to_stream", count, 257);
    step();
    chk("full_pop_blocks_push", count, 256);
    s_valid = 1'b0;
    drain(3000, 1'b1);
    chk("after_full_drain_rd_ptr", arr_rd_ptr, 0);
    chk("after_full_drain_count", {empty, count}, {1'b1, 9'd0});

    // Continuous push and pop across the read pointer wrap.
    m_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      s_valid = 1'b1; s_data = 8'(i);
      exp_q.push_back(s_data);
      step();
      if (i > 0) chk("stream_count_constant", count, 1);
    end
    s_valid = 1'b0;
    drain(100, 1'b0);
    chk("wrap_ptrs", {arr_wr_ptr, arr_rd_ptr}, {9'd43, 9'd43});

    // Return to IDLE, collect 5 words, flush, drain, continue pointers.
    flush = 1'b1; step(); flush = 1'b0; step();
    chk("idle_after_empty_flush_s_ready", s_ready, 1);
    cfg_depth = 9'd10; m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'hA0 + 8'(i);
      exp_q.push_back(s_data);
      step();
    end
    s_valid = 1'b0;
    chk("flush_count5", count, 5);
    flush = 1'b1; step(); flush = 1'b0;
    chk("drain_s_ready", s_ready, 0);
    drain(50, 1'b0);
    chk("drain_to_idle_s_ready", s_ready, 1);
    chk("continuing_wr_ptr", arr_wr_ptr, 48);
    cfg_depth = 9'd1; s_valid = 1'b1; s_data = 8'h77;
    exp_q.push_back(s_data);
    step();
    s_valid = 1'b0;
    chk("next_push_wr_ptr", {arr_wr_ptr, count}, {9'd49, 9'd1});

    // Build up 100 entries, then reset mid-stream.
    m_ready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 3);
      exp_q.push_back(s_data);
      step();
    end
    chk("count_100", count, 100);
    rst = 1'b1; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_stream", {m_valid, m_data, count, arr_wr_ptr, arr_rd_ptr, empty, s_ready},
        {1'b0, 8'h00, 9'd0, 9'd0, 9'd0, 1'b1, 1'b1});
    exp_q.delete();
    prev_hold = 1'b0;

    // Startup latency with depth 1 also proves the state restarted in IDLE.
    rst = 1'b0; cfg_depth = 9'd1; s_valid = 1'b1; s_data = 8'h3C; m_ready = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    chk("latency_c1", {m_valid, count}, {1'b0, 9'd1});
    @(posedge clk); #1;
    chk("latency_c2", m_valid, 0);
    @(posedge clk); #1;
    chk("latency_c3", {m_valid, m_data, count}, {1'b1, 8'h3C, 9'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
`default_nettype wire
